// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, the
// rwmm access-mode encoding and the registered bus payload.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MODE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2
  } arb_state_e;

  // Bit 2 = zero-extend, bits 1:0 = size; matches the pipeline rwmm field.
  typedef enum logic [MODE_W-1:0] {
    MODE_BYTE  = 3'b000,
    MODE_HALF  = 3'b001,
    MODE_WORD  = 3'b010,
    MODE_BYTEU = 3'b100,
    MODE_HALFU = 3'b101
  } acc_mode_e;

  typedef struct packed {
    logic              we;
    logic [MODE_W-1:0] mode;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Transfer watchdog: counts stalled bus cycles and flags the last one
// allowed before the transfer must be aborted.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Saturates at the expiry value; the owner clears it on leaving the transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data
// access, data first, with per-transfer timeout and fetch flush.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_valid,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [MODE_W-1:0] d_mode,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_valid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              stall,
  output logic              m_req,
  output logic              m_we,
  output logic [MODE_W-1:0] m_mode,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_rdata
);

  arb_state_e      state_q, state_d;
  bus_req_t        bus_q, bus_d;
  logic            m_req_q, m_req_d;
  logic            discard_q, discard_d;
  logic            i_valid_q, i_valid_d, i_err_q, i_err_d;
  logic            d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            expired_c, busy_c, done_c, d_elig_c, i_elig_c, i_drop_c;

  // A port in its completion cycle is ineligible so it is never re-granted.
  assign d_elig_c = d_req & ~d_valid_q;
  assign i_elig_c = i_req & ~i_valid_q & ~flush;
  assign busy_c   = (state_q != IDLE);
  assign done_c   = busy_c & (m_ack | expired_c);
  assign i_drop_c = discard_q | flush;
  assign stall    = d_elig_c | i_elig_c;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear     (~busy_c),
    .enable    (busy_c & ~m_ack),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_elig_c) begin
          state_d = D_BUSY;
        end else if (i_elig_c) begin
          state_d = I_BUSY;
        end
      end
      D_BUSY, I_BUSY: begin
        if (done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output; ack beats a same-cycle expiry.
  always_comb begin
    bus_d     = bus_q;
    m_req_d   = m_req_q;
    discard_d = discard_q;
    i_valid_d = 1'b0;
    i_rdata_d = '0;
    i_err_d   = 1'b0;
    d_valid_d = 1'b0;
    d_rdata_d = '0;
    d_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (d_elig_c) begin
          bus_d.we    = d_we;
          bus_d.mode  = d_mode;
          bus_d.addr  = d_addr;
          bus_d.wdata = d_wdata;
          m_req_d     = 1'b1;
        end else if (i_elig_c) begin
          bus_d.we    = 1'b0;
          bus_d.mode  = MODE_WORD;
          bus_d.addr  = i_addr;
          bus_d.wdata = '0;
          m_req_d     = 1'b1;
        end
      end
      D_BUSY: begin
        if (done_c) begin
          m_req_d   = 1'b0;
          d_valid_d = 1'b1;
          d_err_d   = ~m_ack;
          d_rdata_d = (m_ack && !bus_q.we) ? m_rdata : '0;
        end
      end
      I_BUSY: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (done_c) begin
          m_req_d   = 1'b0;
          discard_d = 1'b0;
          i_valid_d = ~i_drop_c;
          i_err_d   = ~i_drop_c & ~m_ack;
          i_rdata_d = (!i_drop_c && m_ack) ? m_rdata : '0;
        end
      end
      default: begin
        m_req_d   = 1'b0;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_q     <= '0;
      m_req_q   <= 1'b0;
      discard_q <= 1'b0;
      i_valid_q <= 1'b0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      bus_q     <= bus_d;
      m_req_q   <= m_req_d;
      discard_q <= discard_d;
      i_valid_q <= i_valid_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = bus_q.we;
  assign m_mode  = bus_q.mode;
  assign m_addr  = bus_q.addr;
  assign m_wdata = bus_q.wdata;
  assign i_valid = i_valid_q;
  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_valid = d_valid_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between the pipeline's instruction-fetch port (IF) and data-access port (MA, loads and stores).
- Fixed priority: data before fetch. A granted transaction is never preempted.
- Each granted transfer has a timeout watchdog.
- Drives a combinational stall that holds the pipeline until each port's pending request completes. A flush input discards in-flight fetch results after a taken branch.

Parameters:
- TIMEOUT, 16: cycles a granted transfer waits for m_ack before it is aborted with an error; legal range 2..65535.
- CNT_W, $clog2(TIMEOUT+1): width of the watchdog counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  taken-branch flush; cancels delivery of the current fetch.
- i_req  in  1  fetch request; level, held until i_valid or flush.
- i_addr  in  32  fetch address (pc).
- i_valid  out  1  one-cycle fetch completion pulse.
- i_rdata  out  32  fetched instruction; valid with i_valid.
- i_err  out  1  fetch timed out; valid with i_valid.
- d_req  in  1  data request; level, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_mode  in  3  access mode (byte/half/word, signedness); same encoding as the pipeline rwmm field.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_valid  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load data; 0 for stores.
- d_err  out  1  data access timed out; valid with d_valid.
- stall  out  1  pipeline hold.
- m_req  out  1  bus request, registered.
- m_we  out  1  bus write enable, registered.
- m_mode  out  3  bus access mode, registered.
- m_addr  out  32  bus address, registered.
- m_wdata  out  32  bus write data, registered.
- m_ack  in  1  one-cycle transfer completion from memory.
- m_rdata  in  32  read data; valid when m_ack=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs go to 0: m_*, i_valid, i_rdata, i_err, d_valid, d_rdata, d_err.
  - Discard flag and watchdog counter are cleared.
  - Reset mid-transfer abandons the transfer with no response pulse.
- States:
  - IDLE: no transfer in progress.
  - D_BUSY: data transfer granted.
  - I_BUSY: fetch transfer granted.
- IDLE grant rules, evaluated each edge:
  - If d_req=1 and d_valid=0, go to D_BUSY.
  - Else if i_req=1, i_valid=0 and flush=0, go to I_BUSY.
  - A port whose valid is high this cycle is not eligible, so a completed request is never re-granted.
- On grant:
  - Latch the winning port's fields into m_we, m_mode, m_addr and m_wdata. For a fetch, m_we=0 and m_mode=word.
  - Set m_req=1 and clear the watchdog counter.
  - m_* stay stable while m_req=1.
- In a BUSY state with m_ack=1:
  - m_req goes to 0 and the next state is IDLE.
  - The owning port's valid pulses for one cycle.
  - rdata = m_rdata for loads and fetches, 0 for stores; err=0.
- In a BUSY state with m_ack=0:
  - The watchdog counter increments.
  - When the counter reaches TIMEOUT-1 and m_ack is still 0: m_req goes to 0, next state is IDLE, valid pulses with err=1 and rdata=0.
  - If m_ack=1 in the same cycle the counter reaches TIMEOUT-1, ack wins.
- Latency: request in IDLE at cycle t gives m_req at t+1. With ack at t+1 (zero-wait memory), valid is at t+2. Back-to-back transfers on the same port are therefore 3 cycles apart.
- Priority:
  - If d_req and i_req are both pending in IDLE, data wins.
  - Fetch is granted on the first IDLE cycle without an eligible data request.
- Flush:
  - flush=1 while in I_BUSY sets the discard flag. The bus transfer still completes, and on ack or timeout i_valid stays 0.
  - flush=1 in IDLE blocks a fetch grant that cycle.
  - The discard flag clears on return to IDLE.
  - flush has no effect on D_BUSY.
- stall is combinational: (d_req & ~d_valid) | (i_req & ~i_valid & ~flush).
- m_ack received in IDLE is ignored.

Decomposition:
- Shared package holds the state enum (IDLE, D_BUSY, I_BUSY) and the access-mode encoding shared with rwmm, including the word constant used for fetches.
- One sub-module, mem_watchdog: CNT_W counter with clear, enable and expired outputs, parameterised by TIMEOUT.

Test Plan:
- Fetch, zero-wait: i_req=1, i_addr=0x100, ack the cycle after m_req with m_rdata=0x00000013 -> m_addr=0x100, m_we=0; i_valid at t+2 with i_rdata=0x13, i_err=0; stall high t..t+1.
- Contention: d_req (load 0x2000, mode word) and i_req (0x104) raised together; memory acks after 2 waits with 0xDEADBEEF -> data served first, d_rdata=0xDEADBEEF; fetch m_req rises the cycle after d_valid.
- Store: d_we=1, d_addr=0x3004, d_wdata=0xA5A5A5A5, mode byte -> m_wdata=0xA5A5A5A5, m_mode=byte, m_we=1; d_valid pulses with d_rdata=0; no re-grant during the d_valid cycle.
- Timeout: TIMEOUT=16, load with m_ack never asserted -> m_req high exactly 16 cycles, then d_valid=1, d_err=1, d_rdata=0; then IDLE.
- Flush: fetch in flight, flush=1 one cycle, ack 3 cycles later -> no i_valid; next fetch to 0x200 is granted normally and completes.
- Reset mid-transfer: drop reset during D_BUSY -> all outputs 0 immediately, no d_valid pulse after release; a subsequent request completes normally.
